bster_cmd_mux: RTL and testbench



---
 rtl/bster_cmd_mux.sv | 165 ++++++++++++++++
 tb/tb_bster_cmd_mux.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bster_cmd_mux.sv
// bster_cmd_mux: round-robin arbiter that merges NB_CHANNEL command streams
// onto the single command stream of the BSTer core. Completions come back
// from the core in command order. An in-order tag FIFO records the channel
// of every grant, and each completion is routed back to that channel.
module bster_cmd_mux #(
    parameter int AXI4S_WIDTH = 128,
    parameter int NB_CHANNEL  = 4,
    parameter int OSTDG_DEPTH = 8,
    parameter int CH_W        = $clog2(NB_CHANNEL),
    parameter int CNT_W       = $clog2(OSTDG_DEPTH) + 1
) (
    input  logic                              aclk,
    input  logic                              rst,
    // per-channel command inputs
    input  logic [NB_CHANNEL-1:0]             cmd_in_tvalid,
    output logic [NB_CHANNEL-1:0]             cmd_in_tready,
    input  logic [NB_CHANNEL*AXI4S_WIDTH-1:0] cmd_in_tdata,
    // merged command stream to the core
    output logic                              cmd_out_tvalid,
    input  logic                              cmd_out_tready,
    output logic [AXI4S_WIDTH-1:0]            cmd_out_tdata,
    // completion stream from the core
    input  logic                              cpl_in_tvalid,
    output logic                              cpl_in_tready,
    input  logic [AXI4S_WIDTH-1:0]            cpl_in_tdata,
    // per-channel completion outputs (data is shared by all channels)
    output logic [NB_CHANNEL-1:0]             cpl_out_tvalid,
    input  logic [NB_CHANNEL-1:0]             cpl_out_tready,
    output logic [AXI4S_WIDTH-1:0]            cpl_out_tdata,
    // status
    output logic [CNT_W-1:0]                  outstanding,
    output logic [CH_W-1:0]                   last_grant
);

    localparam int PTR_W = CNT_W - 1;

    // output slot and round-robin pointer
    logic                   r_cmd_out_tvalid;
    logic [AXI4S_WIDTH-1:0] r_cmd_out_tdata;
    logic [CH_W-1:0]        r_last_grant;

    // tag FIFO: records the channel of every command in flight
    logic [CH_W-1:0]        r_tag_mem [OSTDG_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    logic                   w_slot_free;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_gnt_en;
    logic                   w_found;
    logic                   w_grant;
    logic [CH_W-1:0]        w_rr_idx;
    logic [CH_W-1:0]        w_win;
    logic [AXI4S_WIDTH-1:0] w_win_data;
    logic [CH_W-1:0]        w_head;
    logic                   w_push;
    logic                   w_pop;

    // Full is taken from the registered count only. A pop in the same
    // cycle does not open a slot for a grant; the grant waits one cycle.
    assign w_fifo_full  = (r_count == CNT_W'(OSTDG_DEPTH));
    assign w_fifo_empty = (r_count == '0);
    assign w_slot_free  = !r_cmd_out_tvalid || cmd_out_tready;
    assign w_gnt_en     = w_slot_free && !w_fifo_full && !rst;
    assign w_grant      = w_gnt_en && w_found;
    assign w_push       = w_grant;
    assign w_head       = r_tag_mem[r_rd_ptr];

    // Round-robin search starting at the channel after the last grant
    always_comb begin
        w_found  = 1'b0;
        w_win    = '0;
        w_rr_idx = '0;
        for (int k = 0; k < NB_CHANNEL; k++) begin
            w_rr_idx = CH_W'((int'(r_last_grant) + 1 + k) % NB_CHANNEL);
            if (!w_found && cmd_in_tvalid[w_rr_idx]) begin
                w_found = 1'b1;
                w_win   = w_rr_idx;
            end
        end
    end

    // Assert ready only toward the winning channel, and only when granting
    always_comb begin
        cmd_in_tready = '0;
        if (w_grant) begin
            cmd_in_tready[w_win] = 1'b1;
        end
    end

    // Select the winning channel's command word
    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NB_CHANNEL; i++) begin
            if (w_win == CH_W'(i)) begin
                w_win_data = cmd_in_tdata[i*AXI4S_WIDTH +: AXI4S_WIDTH];
            end
        end
    end

    // Output slot: load on grant, drop when consumed with no new grant
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_cmd_out_tvalid <= 1'b0;
            r_cmd_out_tdata  <= '0;
            r_last_grant     <= CH_W'(NB_CHANNEL - 1);
        end else if (w_grant) begin
            r_cmd_out_tvalid <= 1'b1;
            r_cmd_out_tdata  <= w_win_data;
            r_last_grant     <= w_win;
        end else if (cmd_out_tready) begin
            r_cmd_out_tvalid <= 1'b0;
        end
    end

    assign cmd_out_tvalid = r_cmd_out_tvalid;
    assign cmd_out_tdata  = r_cmd_out_tdata;
    assign last_grant     = r_last_grant;

    // Route the completion at the FIFO head; nothing is routed when no
    // command is in flight, so an unsolicited completion stalls
    always_comb begin
        cpl_out_tvalid = '0;
        if (cpl_in_tvalid && !w_fifo_empty && !rst) begin
            cpl_out_tvalid[w_head] = 1'b1;
        end
    end

    assign cpl_in_tready = cpl_out_tready[w_head] && !w_fifo_empty && !rst;
    assign cpl_out_tdata = cpl_in_tdata;
    assign w_pop         = cpl_in_tvalid && cpl_in_tready;

    // Tag storage: write the granted channel at the write pointer
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= w_win;
        end
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign outstanding = r_count;

endmodule

// File: tb/tb_bster_cmd_mux.sv
// Self-checking bench for bster_cmd_mux: expected commands and completion
// routes are queued when stimulus is driven and checked at each handshake.
module tb_bster_cmd_mux;

    localparam int W = 128;
    localparam int N = 4;
    localparam int D = 8;
    localparam int CH_W = $clog2(N);
    localparam int CNT_W = $clog2(D) + 1;

    logic              aclk = 1'b0;
    logic              rst;
    logic [N-1:0]      cmd_in_tvalid;
    logic [N-1:0]      cmd_in_tready;
    logic [N*W-1:0]    cmd_in_tdata;
    logic              cmd_out_tvalid;
    logic              cmd_out_tready;
    logic [W-1:0]      cmd_out_tdata;
    logic              cpl_in_tvalid;
    logic              cpl_in_tready;
    logic [W-1:0]      cpl_in_tdata;
    logic [N-1:0]      cpl_out_tvalid;
    logic [N-1:0]      cpl_out_tready;
    logic [W-1:0]      cpl_out_tdata;
    logic [CNT_W-1:0]  outstanding;
    logic [CH_W-1:0]   last_grant;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_cmd [$];
    int           exp_cpl [$];

    bster_cmd_mux #(
        .AXI4S_WIDTH(W),
        .NB_CHANNEL (N),
        .OSTDG_DEPTH(D)
    ) u_dut (
        .aclk          (aclk),
        .rst           (rst),
        .cmd_in_tvalid (cmd_in_tvalid),
        .cmd_in_tready (cmd_in_tready),
        .cmd_in_tdata  (cmd_in_tdata),
        .cmd_out_tvalid(cmd_out_tvalid),
        .cmd_out_tready(cmd_out_tready),
        .cmd_out_tdata (cmd_out_tdata),
        .cpl_in_tvalid (cpl_in_tvalid),
        .cpl_in_tready (cpl_in_tready),
        .cpl_in_tdata  (cpl_in_tdata),
        .cpl_out_tvalid(cpl_out_tvalid),
        .cpl_out_tready(cpl_out_tready),
        .cpl_out_tdata (cpl_out_tdata),
        .outstanding   (outstanding),
        .last_grant    (last_grant)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [W-1:0] mkdata(input int tid, input int ch);
        logic [31:0] hi;
        hi = 32'hA5A5_0000 + 32'(tid);
        return {hi, 64'h0123_4567_89AB_CDEF, 32'(ch)};
    endfunction

    task automatic set_data(input int tid);
        for (int c = 0; c < N; c++) cmd_in_tdata[c*W +: W] = mkdata(tid, c);
    endtask

    task automatic expect_grant(input int tid, input int ch);
        exp_cmd.push_back(mkdata(tid, ch));
        exp_cpl.push_back(ch);
    endtask

    // Return completions until every expected command and completion is seen
    task automatic drain();
        cpl_out_tready = '1;
        for (int k = 0; k < 40; k++) begin
            if (exp_cpl.size() == 0 && exp_cmd.size() == 0) break;
            cpl_in_tvalid = 1'b1;
            cpl_in_tdata  = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        cpl_in_tvalid = 1'b0;
        if (exp_cpl.size() != 0 || exp_cmd.size() != 0)
            chk("drain_timeout", W'(exp_cpl.size() + exp_cmd.size()), '0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        exp_cmd.delete();
        exp_cpl.delete();
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    // Scoreboard: compare every command and completion handshake
    always @(negedge aclk) begin
        if (!rst) begin
            if (cmd_out_tvalid && cmd_out_tready) begin
                if (exp_cmd.size() == 0) chk("cmd_unexpected", 1, 0);
                else chk("cmd_data", cmd_out_tdata, exp_cmd.pop_front());
            end
            if (cpl_in_tvalid && cpl_in_tready) begin
                if (exp_cpl.size() == 0) begin
                    chk("cpl_unexpected", 1, 0);
                end else begin
                    chk("cpl_route", W'(cpl_out_tvalid), W'(4'b0001 << exp_cpl.pop_front()));
                    chk("cpl_data", cpl_out_tdata, cpl_in_tdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        cmd_in_tvalid  = '1;
        cmd_in_tdata   = '0;
        cmd_out_tready = 1'b1;
        cpl_in_tvalid  = 1'b1;
        cpl_in_tdata   = '0;
        cpl_out_tready = '1;
        repeat (3) tick();

        // reset values, with every request raised
        @(negedge aclk);
        chk("rst_cmd_in_tready", W'(cmd_in_tready), '0);
        chk("rst_cpl_out_tvalid", W'(cpl_out_tvalid), '0);
        chk("rst_cpl_in_tready", W'(cpl_in_tready), '0);
        chk("rst_cmd_out_tvalid", W'(cmd_out_tvalid), '0);
        chk("rst_cmd_out_tdata", cmd_out_tdata, '0);
        chk("rst_outstanding", W'(outstanding), '0);
        chk("rst_last_grant", W'(last_grant), W'(N - 1));
        tick();
        cmd_in_tvalid = '0;
        cpl_in_tvalid = 1'b0;
        rst = 1'b0;
        tick();

        // single channel
        cmd_in_tdata[2*W +: W] = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66AB;
        exp_cmd.push_back(128'h0123_4567_89AB_CDEF_0011_2233_4455_66AB);
        exp_cpl.push_back(2);
        cmd_in_tvalid = 4'b0100;
        @(negedge aclk);
        chk("single_ready", W'(cmd_in_tready), W'(4'b0100));
        tick();
        cmd_in_tvalid = '0;
        @(negedge aclk);
        chk("single_out_valid", W'(cmd_out_tvalid), W'(1));
        chk("single_last_grant", W'(last_grant), W'(2));
        chk("single_outstanding", W'(outstanding), W'(1));
        tick();
        cpl_in_tdata  = 128'h55;
        cpl_in_tvalid = 1'b1;
        @(negedge aclk);
        chk("single_cpl_valid", W'(cpl_out_tvalid), W'(4'b0100));
        chk("single_cpl_ready", W'(cpl_in_tready), W'(1));
        tick();
        cpl_in_tvalid = 1'b0;
        @(negedge aclk);
        chk("single_outstanding_0", W'(outstanding), '0);
        tick();

        // contention from a fresh reset, up to the outstanding limit
        do_reset(2);
        set_data(2);
        for (int k = 0; k < 8; k++) expect_grant(2, k % N);
        cmd_in_tvalid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            chk("rr_ready", W'(cmd_in_tready), W'(4'b0001 << (k % N)));
            tick();
        end
        @(negedge aclk);
        chk("full_outstanding", W'(outstanding), W'(D));
        chk("full_ready", W'(cmd_in_tready), '0);
        tick();
        // one completion: full still blocks grants in the pop cycle
        cpl_in_tvalid = 1'b1;
        cpl_in_tdata  = 128'h1234;
        @(negedge aclk);
        chk("full_pop_ready", W'(cmd_in_tready), '0);
        tick();
        cpl_in_tvalid = 1'b0;
        expect_grant(2, 0);
        @(negedge aclk);
        chk("refill_ready", W'(cmd_in_tready), W'(4'b0001));
        tick();
        cmd_in_tvalid = '0;
        @(negedge aclk);
        chk("refill_outstanding", W'(outstanding), W'(D));
        drain();
        @(negedge aclk);
        chk("rr_outstanding_0", W'(outstanding), '0);
        tick();

        // backpressure on the core side
        set_data(3);
        cmd_out_tready = 1'b0;
        cmd_in_tvalid  = 4'b0010;
        expect_grant(3, 1);
        @(negedge aclk);
        chk("bp_first_ready", W'(cmd_in_tready), W'(4'b0010));
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk("bp_ready_low", W'(cmd_in_tready), '0);
            chk("bp_valid_hold", W'(cmd_out_tvalid), W'(1));
            chk("bp_data_hold", cmd_out_tdata, mkdata(3, 1));
            tick();
        end
        cmd_in_tvalid  = '0;
        cmd_out_tready = 1'b1;
        tick();

        // completion stall on the destination channel
        cpl_out_tready = '0;
        cpl_in_tvalid  = 1'b1;
        cpl_in_tdata   = 128'h77;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            chk("stall_cpl_ready", W'(cpl_in_tready), '0);
            chk("stall_cpl_valid", W'(cpl_out_tvalid), W'(4'b0010));
            chk("stall_outstanding", W'(outstanding), W'(1));
            tick();
        end
        cpl_out_tready = 4'b0010;
        tick();
        cpl_in_tvalid  = 1'b0;
        cpl_out_tready = '1;
        @(negedge aclk);
        chk("stall_done_outstanding", W'(outstanding), '0);
        tick();

        // unsolicited completion
        cpl_in_tvalid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge aclk);
            chk("unsol_cpl_ready", W'(cpl_in_tready), '0);
            chk("unsol_cpl_valid", W'(cpl_out_tvalid), '0);
            tick();
        end
        cpl_in_tvalid = 1'b0;
        if (exp_cmd.size() != 0 || exp_cpl.size() != 0) chk("queues_empty", 1, 0);

        // reset in the middle of traffic
        set_data(4);
        cmd_in_tvalid = '1;
        expect_grant(4, 2);
        expect_grant(4, 3);
        expect_grant(4, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            chk("mid_ready", W'(cmd_in_tready), W'(4'b0001 << ((k + 2) % N)));
            tick();
        end
        cmd_in_tvalid  = '0;
        cmd_out_tready = 1'b0;
        @(negedge aclk);
        chk("mid_outstanding", W'(outstanding), W'(3));
        chk("mid_out_valid", W'(cmd_out_tvalid), W'(1));
        tick();
        rst = 1'b1;
        exp_cmd.delete();
        exp_cpl.delete();
        cmd_in_tvalid = '1;
        cpl_in_tvalid = 1'b1;
        @(negedge aclk);
        chk("mid_rst_cmd_ready", W'(cmd_in_tready), '0);
        chk("mid_rst_cpl_ready", W'(cpl_in_tready), '0);
        chk("mid_rst_cpl_valid", W'(cpl_out_tvalid), '0);
        tick();
        rst = 1'b0;
        cpl_in_tvalid = 1'b0;
        set_data(5);
        expect_grant(5, 0);
        @(negedge aclk);
        chk("post_rst_out_valid", W'(cmd_out_tvalid), '0);
        chk("post_rst_outstanding", W'(outstanding), '0);
        chk("post_rst_last_grant", W'(last_grant), W'(3));
        chk("post_rst_ready", W'(cmd_in_tready), W'(4'b0001));
        tick();
        cmd_in_tvalid  = '0;
        cmd_out_tready = 1'b1;
        drain();
        @(negedge aclk);
        chk("final_outstanding", W'(outstanding), '0);
        chk("final_last_grant", W'(last_grant), '0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
